// File: rtl/led_matrix_scan_engine.sv
// Row-sequential scan engine for the bi-colour turn-signal LED matrix.
// Generates STOP / LEFT / RIGHT / STRAIGHT patterns with per-row blanking, scrolling and PWM breathing.
//
// dir      | meaning
// DIR_UP   | breath duty rising toward full scale
// DIR_DOWN | breath duty falling toward zero
module led_matrix_scan_engine #(
  parameter int ROWS       = 8,
  parameter int COLS       = 8,
  parameter int SCAN_DIV   = 1000,
  parameter int BLANK_CYC  = 16,
  parameter int SCROLL_DIV = 2**24,
  parameter int PWM_BITS   = 6,
  parameter int BREATH_DIV = 2**14
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [1:0]      mode,
  output logic [ROWS-1:0] row,
  output logic [COLS-1:0] led_r,
  output logic [COLS-1:0] led_g,
  output logic            frame_start
);

  localparam int SLW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int RIW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int OFW = $clog2(COLS);
  localparam int SCW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam int BRW = (BREATH_DIV > 1) ? $clog2(BREATH_DIV) : 1;
  localparam int H   = ROWS / 2;

  localparam logic [SLW-1:0]      SLOT_LAST   = SLW'(SCAN_DIV - 1);
  localparam logic [SLW-1:0]      BLANK_END   = SLW'(BLANK_CYC);
  localparam logic [RIW-1:0]      ROW_LAST    = RIW'(ROWS - 1);
  localparam logic [OFW-1:0]      OFF_LAST    = OFW'(COLS - 1);
  localparam logic [SCW-1:0]      SCROLL_LAST = SCW'(SCROLL_DIV - 1);
  localparam logic [BRW-1:0]      BREATH_LAST = BRW'(BREATH_DIV - 1);
  localparam logic [PWM_BITS-1:0] DUTY_MAX    = '1;
  localparam logic [PWM_BITS-1:0] DUTY_ONE    = PWM_BITS'(1);

  typedef enum logic [1:0] {
    M_STRAIGHT = 2'b00,
    M_LEFT     = 2'b01,
    M_RIGHT    = 2'b10,
    M_STOP     = 2'b11
  } mode_e;

  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;

  logic [SLW-1:0]      slot_cnt_q, slot_cnt_d;
  logic [RIW-1:0]      row_idx_q, row_idx_d;
  logic [SCW-1:0]      scroll_cnt_q, scroll_cnt_d;
  logic [OFW-1:0]      offset_q, offset_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [BRW-1:0]      breath_cnt_q, breath_cnt_d;
  dir_e                dir_q, dir_d;
  mode_e               mode_q, mode_d;
  logic [ROWS-1:0]     row_q, row_d;
  logic [COLS-1:0]     led_r_q, led_r_d, led_g_q, led_g_d;
  logic                frame_start_q, frame_start_d;

  mode_e               mode_cur;
  logic                slot_tc, row_last, mode_chg;
  logic [COLS-1:0]     red_pix, grn_pix;
  int                  r_i, off_i;

  assign mode_cur = mode_e'(mode);
  assign slot_tc  = (slot_cnt_q == SLOT_LAST);
  assign row_last = (row_idx_q == ROW_LAST);
  assign mode_chg = (mode_cur != mode_q);

  // Left arrow: diagonal edges converge on column 0, shaft along the two middle rows.
  function automatic logic left_base(input int r, input int c);
    int d;
    d = (r < H) ? (H - 1 - r) : (r - H);
    return ((d <= c) && (c < H)) || ((d == 0) && (c < COLS - 1));
  endfunction

  function automatic logic straight_base(input int r, input int c);
    if (r < H) return (c == H - 1) || (c == H);
    return ((r - H) <= c) && (c <= COLS - 1 - (r - H));
  endfunction

  always_comb begin
    slot_cnt_d    = slot_tc ? '0 : slot_cnt_q + 1'b1;
    row_idx_d     = row_idx_q;
    frame_start_d = slot_tc && row_last;
    pwm_cnt_d     = pwm_cnt_q + 1'b1;
    mode_d        = mode_cur;
    scroll_cnt_d  = scroll_cnt_q;
    offset_d      = offset_q;
    breath_cnt_d  = breath_cnt_q;
    duty_d        = duty_q;
    dir_d         = dir_q;

    if (slot_tc) row_idx_d = row_last ? '0 : row_idx_q + 1'b1;

    // A pending clear always beats a terminal count on the same edge.
    if (mode_chg || !en) begin
      scroll_cnt_d = '0;
      offset_d     = '0;
    end else if (mode_cur == M_LEFT || mode_cur == M_RIGHT) begin
      if (scroll_cnt_q == SCROLL_LAST) begin
        scroll_cnt_d = '0;
        offset_d     = (offset_q == OFF_LAST) ? '0 : offset_q + 1'b1;
      end else begin
        scroll_cnt_d = scroll_cnt_q + 1'b1;
      end
    end

    if (!en || mode_cur != M_STRAIGHT || mode_chg) begin
      breath_cnt_d = '0;
      duty_d       = '0;
      dir_d        = DIR_UP;
    end else if (breath_cnt_q == BREATH_LAST) begin
      breath_cnt_d = '0;
      if (dir_q == DIR_UP) begin
        duty_d = duty_q + 1'b1;
        if (duty_q == DUTY_MAX - 1'b1) dir_d = DIR_DOWN;
      end else begin
        duty_d = duty_q - 1'b1;
        if (duty_q == DUTY_ONE) dir_d = DIR_UP;
      end
    end else begin
      breath_cnt_d = breath_cnt_q + 1'b1;
    end
  end

  always_comb begin
    red_pix = '0;
    grn_pix = '0;
    r_i     = int'(row_idx_q);
    off_i   = int'(offset_q);
    for (int c = 0; c < COLS; c++) begin
      case (mode_cur)
        M_STOP:   red_pix[c] = (c == r_i) || (c == COLS - 1 - r_i);
        M_LEFT:   grn_pix[c] = left_base(r_i, (c + off_i) % COLS);
        M_RIGHT:  grn_pix[c] = left_base(r_i, COLS - 1 - ((c - off_i + COLS) % COLS));
        default:  grn_pix[c] = straight_base(r_i, c) && (pwm_cnt_q < duty_q);
      endcase
    end

    row_d   = ~({{(ROWS-1){1'b0}}, 1'b1} << row_idx_q);
    led_r_d = '0;
    led_g_d = '0;
    if (en && slot_cnt_q >= BLANK_END) begin
      led_r_d = red_pix;
      led_g_d = grn_pix;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt_q    <= '0;
      row_idx_q     <= '0;
      scroll_cnt_q  <= '0;
      offset_q      <= '0;
      pwm_cnt_q     <= '0;
      duty_q        <= '0;
      breath_cnt_q  <= '0;
      dir_q         <= DIR_UP;
      mode_q        <= M_STRAIGHT;
      row_q         <= '1;
      led_r_q       <= '0;
      led_g_q       <= '0;
      frame_start_q <= 1'b0;
    end else begin
      slot_cnt_q    <= slot_cnt_d;
      row_idx_q     <= row_idx_d;
      scroll_cnt_q  <= scroll_cnt_d;
      offset_q      <= offset_d;
      pwm_cnt_q     <= pwm_cnt_d;
      duty_q        <= duty_d;
      breath_cnt_q  <= breath_cnt_d;
      dir_q         <= dir_d;
      mode_q        <= mode_d;
      row_q         <= row_d;
      led_r_q       <= led_r_d;
      led_g_q       <= led_g_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign row         = row_q;
  assign led_r       = led_r_q;
  assign led_g       = led_g_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_led_matrix_scan_engine.sv
// Scoreboard bench for led_matrix_scan_engine: a time-based reference model queues the expected
// outputs for every clock edge and an independent monitor compares them against the DUT.
module tb_led_matrix_scan_engine;

  localparam int ROWS = 8, COLS = 8, SCAN_DIV = 4, BLANK_CYC = 1;
  localparam int SCROLL_DIV = 32, PWM_BITS = 3, BREATH_DIV = 2;
  localparam int DMAX = 2**PWM_BITS - 1;
  localparam int H = ROWS / 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            en = 1'b1;
  logic [1:0]      mode = 2'b11;
  logic [ROWS-1:0] row;
  logic [COLS-1:0] led_r, led_g;
  logic            frame_start;

  led_matrix_scan_engine #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC),
    .SCROLL_DIV(SCROLL_DIV), .PWM_BITS(PWM_BITS), .BREATH_DIV(BREATH_DIV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
    .row(row), .led_r(led_r), .led_g(led_g), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ROWS-1:0] row;
    logic [COLS-1:0] r;
    logic [COLS-1:0] g;
    logic            fs;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_x;
  int   n_chk = 0;
  int   n_pass = 0;

  // Model state: edges since reset, edges of uninterrupted scrolling, edges of uninterrupted breathing.
  int         mt, ms, mb;
  logic [1:0] mprev;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic lbase(input int r, input int c);
    int d;
    d = (r < H) ? (H - 1 - r) : (r - H);
    return ((d <= c) && (c < H)) || ((d == 0) && (c < COLS - 1));
  endfunction

  function automatic logic sbase(input int r, input int c);
    if (r < H) return (c == H - 1) || (c == H);
    return ((r - H) <= c) && (c <= COLS - 1 - (r - H));
  endfunction

  task automatic model_reset();
    mt = 0; ms = 0; mb = 0; mprev = 2'b11;
  endtask

  task automatic drive(input logic e, input logic [1:0] m);
    exp_t x;
    int slot, r, off, pwm, k, duty;
    en = e;
    mode = m;
    slot = mt % SCAN_DIV;
    r    = (mt / SCAN_DIV) % ROWS;
    off  = (ms / SCROLL_DIV) % COLS;
    pwm  = mt % (DMAX + 1);
    k    = (mb / BREATH_DIV) % (2 * DMAX);
    duty = (k <= DMAX) ? k : 2 * DMAX - k;
    x.row = ~(8'(1) << r);
    x.fs  = ((mt + 1) % (SCAN_DIV * ROWS)) == 0;
    x.r   = '0;
    x.g   = '0;
    if (e && slot >= BLANK_CYC) begin
      for (int c = 0; c < COLS; c++) begin
        case (m)
          2'b11:   x.r[c] = (c == r) || (c == COLS - 1 - r);
          2'b01:   x.g[c] = lbase(r, (c + off) % COLS);
          2'b10:   x.g[c] = lbase(r, COLS - 1 - ((c - off + COLS) % COLS));
          default: x.g[c] = sbase(r, c) && (pwm < duty);
        endcase
      end
    end
    sbq.push_back(x);
    if (m != mprev || !e) ms = 0;
    else if (m == 2'b01 || m == 2'b10) ms++;
    if (!e || m != 2'b00 || m != mprev) mb = 0;
    else mb++;
    mprev = m;
    mt++;
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    #2;
    if (rst_n && sbq.size() > 0) begin
      mon_x = sbq.pop_front();
      check("row_frame", 32'({row, frame_start}), 32'({mon_x.row, mon_x.fs}));
      check("leds", 32'({led_r, led_g}), 32'({mon_x.r, mon_x.g}));
    end
  end

  task automatic check_reset_state(input string tag);
    check({tag, "_row"}, 32'(row), 32'({ROWS{1'b1}}));
    check({tag, "_leds"}, 32'({led_r, led_g}), 32'd0);
    check({tag, "_frame"}, 32'(frame_start), 32'd0);
  endtask

  initial begin
    int m;
    int len;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_state("por");
    rst_n = 1'b1;

    repeat (64) drive(1'b1, 2'b11);
    repeat (300) drive(1'b1, 2'b01);
    repeat (100) drive(1'b1, 2'b10);
    repeat (80) drive(1'b1, 2'b00);
    repeat (20) drive(1'b1, 2'b11);

    // LEFT up to offset 5, one-cycle en drop, then switch to RIGHT on a scroll terminal edge.
    repeat (5 * SCROLL_DIV + 4) drive(1'b1, 2'b01);
    drive(1'b0, 2'b01);
    repeat (SCROLL_DIV - 1) drive(1'b1, 2'b01);
    repeat (40) drive(1'b1, 2'b10);

    repeat (25) begin
      m   = $urandom_range(0, 3);
      len = $urandom_range(10, 120);
      repeat (len) drive(($urandom_range(0, 15) != 0), 2'(m));
    end

    repeat (10) drive(1'b1, 2'b11);
    #2;
    rst_n = 1'b0;
    sbq.delete();
    #1;
    check_reset_state("async_rst");
    repeat (3) @(negedge clk);
    check_reset_state("rst_held");
    rst_n = 1'b1;
    model_reset();
    repeat (40) drive(1'b1, 2'b11);
    repeat (10) begin
      m   = $urandom_range(0, 3);
      len = $urandom_range(10, 80);
      repeat (len) drive(($urandom_range(0, 15) != 0), 2'(m));
    end

    @(posedge clk);
    #3;
    check("sb_drain", 32'(sbq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
